// File: rtl/pipe_stage_fifo.sv
`default_nettype none
// ============================================================================
// Module   : pipe_stage_fifo
// Brief    : Elastic valid/ready buffer carrying one stage-register payload
//            between adjacent pipeline stages, with occupancy and flush.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_stage_fifo #(
    parameter int PAYLOAD_W = 65,
    parameter int DEPTH     = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [PAYLOAD_W-1:0]         in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [PAYLOAD_W-1:0]         out_data,
    input  logic                         flush,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int C_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int C_CNT_W = $clog2(DEPTH + 1);
    localparam logic [C_PTR_W-1:0] C_LAST_IDX = C_PTR_W'(DEPTH - 1);

    logic [PAYLOAD_W-1:0] r_mem [DEPTH];
    logic [C_PTR_W-1:0]   r_wr_ptr;
    logic [C_PTR_W-1:0]   r_rd_ptr;
    logic [C_CNT_W-1:0]   r_count;
    logic                 w_push;
    logic                 w_pop;

    function automatic logic [C_PTR_W-1:0] f_next(input logic [C_PTR_W-1:0] ptr);
        return (ptr == C_LAST_IDX) ? '0 : ptr + 1'b1;
    endfunction

    generate
        if (DEPTH == 1) begin : g_ready_pass
            // Single entry: a same-cycle pop frees the slot, keeping full rate.
            assign in_ready = (r_count == '0) | out_ready;
        end else begin : g_ready_reg
            localparam logic [C_CNT_W-1:0] C_DEPTH = C_CNT_W'(DEPTH);
            assign in_ready = (r_count < C_DEPTH);
        end
    endgenerate

    assign out_valid = (r_count != '0) & ~flush;
    assign out_data  = r_mem[r_rd_ptr];
    assign count     = r_count;
    assign w_push    = in_valid & in_ready & ~flush;
    assign w_pop     = out_valid & out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (flush) begin
            // Storage contents are left stale; the pointers alone retire them.
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= in_data;
                r_wr_ptr        <= f_next(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= f_next(r_rd_ptr);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_stage_fifo
// Brief    : Four buffers (DEPTH 1..4) driven together and checked against
//            queue models every cycle, plus directed literal expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_stage_fifo;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid  [4];
    logic        in_ready  [4];
    logic [64:0] in_data   [4];
    logic        out_valid [4];
    logic        out_ready [4];
    logic [64:0] out_data  [4];
    logic        flush     [4];
    logic [3:0]  cnt       [4];

    logic [64:0] mq [4][$];
    logic        pend_v [4];
    logic [64:0] pend_d [4];
    int          checks   = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        localparam int D = g + 1;
        logic [$clog2(D+1)-1:0] c;
        pipe_stage_fifo #(.PAYLOAD_W(65), .DEPTH(D)) u_dut (
            .clk      (clk),
            .rst_n    (rst_n),
            .in_valid (in_valid[g]),
            .in_ready (in_ready[g]),
            .in_data  (in_data[g]),
            .out_valid(out_valid[g]),
            .out_ready(out_ready[g]),
            .out_data (out_data[g]),
            .flush    (flush[g]),
            .count    (c)
        );
        assign cnt[g] = 4'(c);
    end

    task automatic chk(input string name, input logic [64:0] act, input logic [64:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_idle();
        for (int i = 0; i < 4; i++) begin
            in_valid[i]  = 1'b0;
            out_ready[i] = 1'b0;
            flush[i]     = 1'b0;
            in_data[i]   = '0;
        end
    endtask

    // Compare every instance against its queue model, then advance the model.
    task automatic settle_check();
        int   sz;
        logic ev, er, push, pop;
        #2;
        for (int i = 0; i < 4; i++) begin
            sz = mq[i].size();
            ev = (sz != 0) && !flush[i];
            er = (i == 0) ? (sz == 0 || out_ready[i]) : (sz < i + 1);
            chk($sformatf("d%0d.count", i + 1), 65'(cnt[i]), 65'(sz));
            chk($sformatf("d%0d.out_valid", i + 1), 65'(out_valid[i]), 65'(ev));
            chk($sformatf("d%0d.in_ready", i + 1), 65'(in_ready[i]), 65'(er));
            if (ev) chk($sformatf("d%0d.out_data", i + 1), out_data[i], mq[i][0]);
            push = in_valid[i] && er && !flush[i];
            pop  = ev && out_ready[i];
            if (flush[i]) begin
                mq[i].delete();
            end else begin
                if (pop)  void'(mq[i].pop_front());
                if (push) mq[i].push_back(in_data[i]);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drain(input int n);
        for (int k = 0; k < n; k++) begin
            set_idle();
            for (int i = 0; i < 4; i++) out_ready[i] = 1'b1;
            settle_check();
            tick();
        end
    endtask

    initial begin
        rst_n = 1'b0;
        set_idle();
        #2;
        for (int i = 0; i < 4; i++) begin
            chk("reset.out_valid", 65'(out_valid[i]), 65'd0);
            chk("reset.out_data", out_data[i], 65'd0);
            chk("reset.in_ready", 65'(in_ready[i]), 65'd1);
            chk("reset.count", 65'(cnt[i]), 65'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        // Streaming through DEPTH=2: one per cycle, occupancy pinned at 1.
        for (int k = 0; k < 10; k++) begin
            set_idle();
            in_valid[1]  = (k < 8);
            in_data[1]   = 65'(k + 1);
            out_ready[1] = 1'b1;
            settle_check();
            if (k == 0 || k == 9) chk("stream.out_valid_idle", 65'(out_valid[1]), 65'd0);
            if (k >= 1 && k <= 8) begin
                chk("stream.out_valid", 65'(out_valid[1]), 65'd1);
                chk("stream.out_data", out_data[1], 65'(k));
                chk("stream.count", 65'(cnt[1]), 65'd1);
            end
            tick();
        end

        // Fill DEPTH=3 under backpressure, then release.
        for (int k = 0; k < 9; k++) begin
            set_idle();
            in_valid[2]  = (k < 6);
            in_data[2]   = (k < 3) ? 65'(10 + k) : 65'hD;
            out_ready[2] = (k >= 4);
            settle_check();
            if (k == 3) begin
                chk("fill.count", 65'(cnt[2]), 65'd3);
                chk("fill.in_ready", 65'(in_ready[2]), 65'd0);
            end
            if (k == 4) chk("fill.in_ready_full_pop", 65'(in_ready[2]), 65'd0);
            if (k == 5) chk("fill.count_after_pop", 65'(cnt[2]), 65'd2);
            if (k >= 4 && k <= 7) chk("fill.out_data", out_data[2], 65'(10 + k - 4));
            tick();
        end

        // Randomized traffic on all depths, holding data until accepted.
        for (int i = 0; i < 4; i++) pend_v[i] = 1'b0;
        for (int k = 0; k < 300; k++) begin
            for (int i = 0; i < 4; i++) begin
                if (!pend_v[i]) begin
                    pend_v[i] = ($urandom_range(0, 2) != 0);
                    pend_d[i] = {1'($urandom), $urandom, $urandom};
                end
                in_valid[i]  = pend_v[i];
                in_data[i]   = pend_d[i];
                out_ready[i] = ($urandom_range(0, 3) != 0);
                flush[i]     = ($urandom_range(0, 24) == 0);
            end
            settle_check();
            for (int i = 0; i < 4; i++) begin
                if (in_valid[i] && in_ready[i]) pend_v[i] = 1'b0;
            end
            tick();
        end
        drain(6);

        // Flush DEPTH=2 holding two entries, with a push offered alongside.
        for (int k = 0; k < 7; k++) begin
            set_idle();
            in_valid[1]  = (k <= 2);
            in_data[1]   = (k == 0) ? 65'h11 : (k == 1) ? 65'h22 : 65'h55;
            flush[1]     = (k == 2);
            out_ready[1] = (k >= 2);
            settle_check();
            if (k == 2) begin
                chk("flush.out_valid", 65'(out_valid[1]), 65'd0);
                chk("flush.count_held", 65'(cnt[1]), 65'd2);
            end
            if (k == 3) begin
                chk("flush.count_after", 65'(cnt[1]), 65'd0);
                chk("flush.out_valid_after", 65'(out_valid[1]), 65'd0);
            end
            tick();
        end

        // DEPTH=1 pass-through, then same-cycle ready drop.
        for (int k = 0; k < 8; k++) begin
            set_idle();
            in_valid[0]  = 1'b1;
            in_data[0]   = 65'h100 + 65'((k > 6) ? 6 : k);
            out_ready[0] = (k != 6);
            settle_check();
            if (k >= 1 && k <= 5) begin
                chk("pass.in_ready", 65'(in_ready[0]), 65'd1);
                chk("pass.out_valid", 65'(out_valid[0]), 65'd1);
                chk("pass.out_data", out_data[0], 65'h100 + 65'(k - 1));
                chk("pass.count", 65'(cnt[0]), 65'd1);
            end
            if (k == 6) begin
                chk("pass.in_ready_drop", 65'(in_ready[0]), 65'd0);
                chk("pass.out_data_hold", out_data[0], 65'h105);
            end
            tick();
        end
        drain(3);

        // Asynchronous reset with DEPTH=4 holding three entries.
        for (int k = 0; k < 3; k++) begin
            set_idle();
            in_valid[3] = 1'b1;
            in_data[3]  = 65'h31 + 65'(k);
            settle_check();
            tick();
        end
        set_idle();
        #2;
        rst_n = 1'b0;
        #1;
        chk("areset.out_valid", 65'(out_valid[3]), 65'd0);
        chk("areset.count", 65'(cnt[3]), 65'd0);
        chk("areset.out_data", out_data[3], 65'd0);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) mq[i].delete();
        tick();
        set_idle();
        in_valid[3]  = 1'b1;
        in_data[3]   = 65'h77;
        out_ready[3] = 1'b1;
        settle_check();
        tick();
        set_idle();
        out_ready[3] = 1'b1;
        settle_check();
        chk("areset.first_out_valid", 65'(out_valid[3]), 65'd1);
        chk("areset.first_out_data", out_data[3], 65'h77);
        tick();
        drain(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
